// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared ALU port and the conflict
// counter for alu_arbiter. The slave modport is the arbiter's view and the
// master modport is the view of whatever sits around it: the requesters,
// the shared ALU and an observer of the counter.
interface alu_arbiter_if;
  // Requester 0 request and response channels
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        rsp0_valid;
  logic [31:0] rsp0_result;
  logic        rsp0_ready;

  // Requester 1 request and response channels
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp1_valid;
  logic [31:0] rsp1_result;
  logic        rsp1_ready;

  // Shared ALU port
  logic [3:0]  alu_control;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_result;

  // Lost-arbitration statistics
  logic [15:0] conflict_cnt;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  alu_result,
    output req0_ready, rsp0_valid, rsp0_result,
    output req1_ready, rsp1_valid, rsp1_result,
    output alu_control, alu_in1, alu_in2,
    output conflict_cnt
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output alu_result,
    input  req0_ready, rsp0_valid, rsp0_result,
    input  req1_ready, rsp1_valid, rsp1_result,
    input  alu_control, alu_in1, alu_in2,
    input  conflict_cnt
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Each cycle at most one eligible requester is granted. Its operation goes
// to the ALU, and the result is captured into that requester's 1-entry
// response register. A requester whose response register is still full
// and is not being drained this cycle is not eligible. Ties go round-robin
// when FAIR != 0; otherwise requester 0 always wins a tie.
module alu_arbiter #(
  parameter int FAIR = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic        w_elig0;
  logic        w_elig1;
  logic        w_tie;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_fair;

  logic        r_last_grant;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [31:0] r_rsp0_result;
  logic [31:0] r_rsp1_result;
  logic [15:0] r_conflict_cnt;

  assign w_fair = (FAIR != 0);

  // A requester can issue when its response slot is empty or is being drained
  // in the same cycle. rst_n is folded in so nothing is granted during reset.
  assign w_elig0 = rst_n & bus.req0_valid & (~r_rsp0_valid | bus.rsp0_ready);
  assign w_elig1 = rst_n & bus.req1_valid & (~r_rsp1_valid | bus.rsp1_ready);
  assign w_tie   = w_elig0 & w_elig1;

  // Grant selection: a lone eligible requester always wins. On a tie, round-robin
  // grants the requester that was not granted last; fixed priority picks 0.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_tie) begin
      if (w_fair) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else begin
        w_grant0 = 1'b1;
      end
    end else begin
      w_grant0 = w_elig0;
      w_grant1 = w_elig1;
    end
  end

  // Route the granted requester's operation to the shared ALU; drive zeros when idle
  always_comb begin
    bus.alu_control = 4'd0;
    bus.alu_in1     = 32'd0;
    bus.alu_in2     = 32'd0;
    if (w_grant0) begin
      bus.alu_control = bus.req0_op;
      bus.alu_in1     = bus.req0_a;
      bus.alu_in2     = bus.req0_b;
    end else if (w_grant1) begin
      bus.alu_control = bus.req1_op;
      bus.alu_in1     = bus.req1_a;
      bus.alu_in2     = bus.req1_b;
    end
  end

  // Remember who won last. The reset value of 1 makes the first tie go to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_grant0) begin
      r_last_grant <= 1'b0;
    end else if (w_grant1) begin
      r_last_grant <= 1'b1;
    end
  end

  // Requester 0 response slot: a new result overrides a drain, so back-to-back ops flow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= 32'd0;
    end else if (w_grant0) begin
      r_rsp0_valid  <= 1'b1;
      r_rsp0_result <= bus.alu_result;
    end else if (bus.rsp0_ready) begin
      r_rsp0_valid  <= 1'b0;
    end
  end

  // Requester 1 response slot: same policy as requester 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= 32'd0;
    end else if (w_grant1) begin
      r_rsp1_valid  <= 1'b1;
      r_rsp1_result <= bus.alu_result;
    end else if (bus.rsp1_ready) begin
      r_rsp1_valid  <= 1'b0;
    end
  end

  // Count tie cycles, where one eligible requester necessarily loses; saturate rather than wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= 16'd0;
    end else if (w_tie && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign bus.req0_ready   = w_grant0;
  assign bus.req1_ready   = w_grant1;
  assign bus.rsp0_valid   = r_rsp0_valid;
  assign bus.rsp0_result  = r_rsp0_result;
  assign bus.rsp1_valid   = r_rsp1_valid;
  assign bus.rsp1_result  = r_rsp1_result;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. dutFair (FAIR=1) gets directed vectors. Their expected
// responses go into per-requester queues that an independent monitor drains.
// dutPrio (FAIR=0) covers fixed priority and counter saturation.
module tb_alu_arbiter;

  typedef struct {
    bit          v0;
    logic [3:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] res0;
    bit          v1;
    logic [3:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] res1;
    bit          rr0;
    bit          rr1;
    bit          g0;
    bit          g1;
    logic [15:0] cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  vec_t        vecs[20];

  alu_arbiter_if busF ();
  alu_arbiter_if busP ();

  alu_arbiter #(.FAIR(1)) dutFair (.clk(clk), .rst_n(rst_n), .bus(busF));
  alu_arbiter #(.FAIR(0)) dutPrio (.clk(clk), .rst_n(rst_n), .bus(busP));

  // Reference for the shared ALU that the arbiter drives
  function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      4'd0:    aluModel = a + b;
      4'd1:    aluModel = a - b;
      4'd2:    aluModel = a & b;
      4'd3:    aluModel = a | b;
      4'd4:    aluModel = a ^ b;
      4'd5:    aluModel = a << b[4:0];
      4'd6:    aluModel = a >> b[4:0];
      default: aluModel = 32'd0;
    endcase
  endfunction

  assign busF.alu_result = aluModel(busF.alu_control, busF.alu_in1, busF.alu_in2);
  assign busP.alu_result = aluModel(busP.alu_control, busP.alu_in1, busP.alu_in2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic vec_t mkVec(
    input bit v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
    input logic [31:0] res0,
    input bit v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
    input logic [31:0] res1,
    input bit rr0, input bit rr1, input bit g0, input bit g1, input logic [15:0] cnt);
    vec_t v;
    v.v0 = v0;  v.op0 = op0;  v.a0 = a0;  v.b0 = b0;  v.res0 = res0;
    v.v1 = v1;  v.op1 = op1;  v.a1 = a1;  v.b1 = b1;  v.res1 = res1;
    v.rr0 = rr0;  v.rr1 = rr1;  v.g0 = g0;  v.g1 = g1;  v.cnt = cnt;
    return v;
  endfunction

  // Drive one cycle on dutFair, check grants/ALU mux/counter, and queue the expected results
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [3:0]  expOp;
    logic [31:0] expIn1;
    logic [31:0] expIn2;
    busF.req0_valid = v.v0;  busF.req0_op = v.op0;  busF.req0_a = v.a0;  busF.req0_b = v.b0;
    busF.req1_valid = v.v1;  busF.req1_op = v.op1;  busF.req1_a = v.a1;  busF.req1_b = v.b1;
    busF.rsp0_ready = v.rr0;
    busF.rsp1_ready = v.rr1;
    expOp  = v.g0 ? v.op0 : (v.g1 ? v.op1 : 4'd0);
    expIn1 = v.g0 ? v.a0  : (v.g1 ? v.a1  : 32'd0);
    expIn2 = v.g0 ? v.b0  : (v.g1 ? v.b1  : 32'd0);
    @(negedge clk);
    checkOutput($sformatf("v%0d req0_ready", idx), 32'(busF.req0_ready), 32'(v.g0));
    checkOutput($sformatf("v%0d req1_ready", idx), 32'(busF.req1_ready), 32'(v.g1));
    checkOutput($sformatf("v%0d alu_control", idx), 32'(busF.alu_control), 32'(expOp));
    checkOutput($sformatf("v%0d alu_in1", idx), busF.alu_in1, expIn1);
    checkOutput($sformatf("v%0d alu_in2", idx), busF.alu_in2, expIn2);
    checkOutput($sformatf("v%0d conflict_cnt", idx), 32'(busF.conflict_cnt), 32'(v.cnt));
    @(posedge clk);
    #1;
    if (v.g0) q0.push_back(v.res0);
    if (v.g1) q1.push_back(v.res1);
  endtask

  // Response monitor: a response must be pending exactly when the scoreboard holds one
  always @(negedge clk) begin
    checkOutput("mon rsp0_valid", 32'(busF.rsp0_valid), 32'(q0.size() != 0));
    if (busF.rsp0_valid && (q0.size() != 0)) begin
      checkOutput("mon rsp0_result", busF.rsp0_result, q0[0]);
      if (busF.rsp0_ready) void'(q0.pop_front());
    end
    checkOutput("mon rsp1_valid", 32'(busF.rsp1_valid), 32'(q1.size() != 0));
    if (busF.rsp1_valid && (q1.size() != 0)) begin
      checkOutput("mon rsp1_result", busF.rsp1_result, q1[0]);
      if (busF.rsp1_ready) void'(q1.pop_front());
    end
  end

  initial begin
    checks = 0;
    errors = 0;

    // Single op, then round-robin ties, then backpressure on requester 0
    vecs[0]  = mkVec(1, 4'd0, 32'd5, 32'd7, 32'd12,          0, 4'd0, 32'd0, 32'd0, 32'd0,           1, 1, 1, 0, 16'd0);
    vecs[1]  = mkVec(0, 4'd0, 32'd0, 32'd0, 32'd0,           0, 4'd0, 32'd0, 32'd0, 32'd0,           1, 1, 0, 0, 16'd0);
    vecs[2]  = mkVec(1, 4'd0, 32'd100, 32'd23, 32'd123,      1, 4'd1, 32'd10, 32'd3, 32'd7,          1, 1, 0, 1, 16'd0);
    vecs[3]  = mkVec(1, 4'd0, 32'd100, 32'd23, 32'd123,      1, 4'd1, 32'd10, 32'd3, 32'd7,          1, 1, 1, 0, 16'd1);
    vecs[4]  = mkVec(1, 4'd0, 32'd100, 32'd23, 32'd123,      1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1, 1, 0, 1, 16'd2);
    vecs[5]  = mkVec(1, 4'd4, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1, 4'd1, 32'd10, 32'd3, 32'd7, 1, 1, 1, 0, 16'd3);
    vecs[6]  = mkVec(1, 4'd0, 32'd100, 32'd23, 32'd123,      1, 4'd3, 32'h000000F0, 32'h0000000F, 32'h000000FF, 0, 1, 0, 1, 16'd4);
    vecs[7]  = mkVec(1, 4'd0, 32'd100, 32'd23, 32'd123,      1, 4'd1, 32'd1, 32'd2, 32'hFFFFFFFF,    0, 1, 0, 1, 16'd4);
    vecs[8]  = mkVec(1, 4'd0, 32'd100, 32'd23, 32'd123,      1, 4'd5, 32'd1, 32'd31, 32'h80000000,   0, 1, 0, 1, 16'd4);
    vecs[9]  = mkVec(1, 4'd6, 32'h80000000, 32'd4, 32'h08000000, 1, 4'd1, 32'd10, 32'd3, 32'd7,      1, 1, 1, 0, 16'd4);
    vecs[10] = mkVec(1, 4'd0, 32'd100, 32'd23, 32'd123,      1, 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0,    1, 1, 0, 1, 16'd5);
    // Drain with no new grant, stray ready, ignored loser operands, full-slot ineligibility
    vecs[11] = mkVec(0, 4'd0, 32'd0, 32'd0, 32'd0,           0, 4'd0, 32'd0, 32'd0, 32'd0,           1, 1, 0, 0, 16'd6);
    vecs[12] = mkVec(0, 4'hF, 32'hDEADBEEF, 32'h12345678, 32'd0, 1, 4'd0, 32'd3, 32'd4, 32'd7,       1, 1, 0, 1, 16'd6);
    vecs[13] = mkVec(1, 4'd0, 32'd1, 32'd1, 32'd2,           0, 4'd0, 32'd0, 32'd0, 32'd0,           0, 1, 1, 0, 16'd6);
    vecs[14] = mkVec(1, 4'd0, 32'd1, 32'd1, 32'd2,           1, 4'd1, 32'd9, 32'd4, 32'd5,           0, 1, 0, 1, 16'd6);
    vecs[15] = mkVec(0, 4'd0, 32'd0, 32'd0, 32'd0,           0, 4'd0, 32'd0, 32'd0, 32'd0,           1, 1, 0, 0, 16'd6);
    vecs[16] = mkVec(1, 4'd0, 32'd2, 32'd2, 32'd4,           0, 4'd0, 32'd0, 32'd0, 32'd0,           0, 1, 1, 0, 16'd6);
    // After a mid-operation reset: the first tie goes to requester 0
    vecs[17] = mkVec(1, 4'd0, 32'd7, 32'd8, 32'd15,          1, 4'd1, 32'd20, 32'd5, 32'd15,         1, 1, 1, 0, 16'd0);
    vecs[18] = mkVec(1, 4'd0, 32'd7, 32'd8, 32'd15,          1, 4'd1, 32'd20, 32'd5, 32'd15,         1, 1, 0, 1, 16'd1);
    vecs[19] = mkVec(0, 4'd0, 32'd0, 32'd0, 32'd0,           0, 4'd0, 32'd0, 32'd0, 32'd0,           1, 1, 0, 0, 16'd2);

    busP.req0_valid = 1'b0;  busP.req0_op = 4'd0;  busP.req0_a = 32'd0;  busP.req0_b = 32'd0;
    busP.req1_valid = 1'b0;  busP.req1_op = 4'd0;  busP.req1_a = 32'd0;  busP.req1_b = 32'd0;
    busP.rsp0_ready = 1'b1;  busP.rsp1_ready = 1'b1;

    // Hold reset with active requests: no grant and quiet ALU outputs
    rst_n = 1'b0;
    busF.req0_valid = 1'b1;  busF.req0_op = 4'd3;  busF.req0_a = 32'h11;  busF.req0_b = 32'h22;
    busF.req1_valid = 1'b1;  busF.req1_op = 4'd1;  busF.req1_a = 32'h33;  busF.req1_b = 32'h44;
    busF.rsp0_ready = 1'b1;  busF.rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req0_ready", 32'(busF.req0_ready), 32'd0);
    checkOutput("reset req1_ready", 32'(busF.req1_ready), 32'd0);
    checkOutput("reset alu_control", 32'(busF.alu_control), 32'd0);
    checkOutput("reset alu_in1", busF.alu_in1, 32'd0);
    checkOutput("reset rsp0_result", busF.rsp0_result, 32'd0);
    checkOutput("reset rsp1_result", busF.rsp1_result, 32'd0);
    checkOutput("reset conflict_cnt", 32'(busF.conflict_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i <= 16; i++) applyStimulus(vecs[i], i);

    // Requester 0 now holds an undrained result; reset must discard it immediately
    checkOutput("prereset rsp0_valid", 32'(busF.rsp0_valid), 32'd1);
    checkOutput("prereset rsp0_result", busF.rsp0_result, 32'd4);
    busF.req1_valid = 1'b1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    checkOutput("midreset rsp0_valid", 32'(busF.rsp0_valid), 32'd0);
    checkOutput("midreset rsp0_result", busF.rsp0_result, 32'd0);
    checkOutput("midreset req0_ready", 32'(busF.req0_ready), 32'd0);
    checkOutput("midreset req1_ready", 32'(busF.req1_ready), 32'd0);
    checkOutput("midreset alu_in1", busF.alu_in1, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 17; i <= 19; i++) applyStimulus(vecs[i], i);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drained q0", 32'(q0.size()), 32'd0);
    checkOutput("drained q1", 32'(q1.size()), 32'd0);

    // Fixed priority under a continuous tie, run long enough to saturate the counter
    busP.req0_valid = 1'b1;  busP.req0_op = 4'd0;  busP.req0_b = 32'd1;
    busP.req1_valid = 1'b1;  busP.req1_op = 4'd1;  busP.req1_a = 32'd50;  busP.req1_b = 32'd8;
    for (int k = 0; k < 70000; k++) begin
      busP.req0_a = 32'(k);
      @(negedge clk);
      if (k < 4) begin
        checkOutput($sformatf("prio k%0d req0_ready", k), 32'(busP.req0_ready), 32'd1);
        checkOutput($sformatf("prio k%0d req1_ready", k), 32'(busP.req1_ready), 32'd0);
      end
      if ((k >= 1) && (k <= 4)) begin
        checkOutput($sformatf("prio k%0d rsp0_valid", k), 32'(busP.rsp0_valid), 32'd1);
        checkOutput($sformatf("prio k%0d rsp0_result", k), busP.rsp0_result, 32'(k));
        checkOutput($sformatf("prio k%0d rsp1_valid", k), 32'(busP.rsp1_valid), 32'd0);
      end
      if ((k <= 2) || (k == 65534) || (k == 65535) || (k == 69999)) begin
        checkOutput($sformatf("prio k%0d conflict_cnt", k), 32'(busP.conflict_cnt),
                    (k < 65535) ? 32'(k) : 32'h0000FFFF);
      end
      if (k == 69999) begin
        checkOutput("prio end req1_ready", 32'(busP.req1_ready), 32'd0);
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
